// File: rtl/c2f_chunk_ring.sv
// c2f_chunk_ring
//   Card-to-FPGA chunk ring reader. The host advances a write pointer (in
//   chunks); this block streams every line of each pending chunk out of the
//   chunk RAM, in order, on a valid/ready stream. After each chunk it asks for
//   the new read pointer to be DMA'd back to the host metrics buffer.
//
//   Optional feature macro: C2F_RDPTR_COALESCE_EN
//     undefined : every finished chunk raises a read-pointer request and reads
//                 stop until that request is acked (one request per chunk).
//     defined   : reads keep going while a request is pending; chunks finished
//                 meanwhile are folded into one follow-up request that carries
//                 the latest read pointer.
//
// Ports
//   clk_in, reset_in     clock, asynchronous active-high reset
//   enable_in            low = synchronous clear of the whole block
//   wrPtrValid_in/wrPtr_in  host write-pointer register write
//   ramAddr_out/ramRead_out/ramData_in  chunk RAM, data one cycle after strobe
//   data_out/dataValid_out/dataReady_in  line stream to the consumer
//   rdPtr_out/rdPtrReq_out/rdPtrAck_in   read-pointer write-back request
//   avail_out            chunks pending = wrPtr - rdPtr (mod ring size)

module c2f_chunk_ring #(
   parameter int NUM_CHUNKS_LOG2 = 2,
   parameter int LINES_LOG2      = 3,
   parameter int DATA_W          = 64
) (
   input  logic                                 clk_in,
   input  logic                                 reset_in,
   input  logic                                 enable_in,
   input  logic                                 wrPtrValid_in,
   input  logic [NUM_CHUNKS_LOG2-1:0]           wrPtr_in,
   output logic [NUM_CHUNKS_LOG2+LINES_LOG2-1:0] ramAddr_out,
   output logic                                 ramRead_out,
   input  logic [DATA_W-1:0]                    ramData_in,
   output logic [DATA_W-1:0]                    data_out,
   output logic                                 dataValid_out,
   input  logic                                 dataReady_in,
   output logic [NUM_CHUNKS_LOG2-1:0]           rdPtr_out,
   output logic                                 rdPtrReq_out,
   input  logic                                 rdPtrAck_in,
   output logic [NUM_CHUNKS_LOG2-1:0]           avail_out
);

   localparam int CW = NUM_CHUNKS_LOG2;
   localparam int LW = LINES_LOG2;

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_ACK} state_t;

   state_t            state;
   logic [CW-1:0]     wr_ptr;
   logic [CW-1:0]     rd_ptr;
   logic [CW-1:0]     req_ptr;
   logic [LW-1:0]     line;
   logic              req;
   logic              rd_pend;      // read strobed last cycle, data on ramData_in now
   logic [1:0]        fifo_cnt;
   logic [DATA_W-1:0] fifo_q0;      // head
   logic [DATA_W-1:0] fifo_q1;
`ifdef C2F_RDPTR_COALESCE_EN
   logic              dirty;        // rdPtr moved while a request was pending
`endif

   logic empty;
   logic blocked;
   logic issue;
   logic last_line;
   logic pop;

   assign empty = (rd_ptr == wr_ptr);

`ifdef C2F_RDPTR_COALESCE_EN
   assign blocked = 1'b0;
`else
   // The ack cycle itself may already issue, so a promptly acked request
   // costs no bubble between chunks.
   assign blocked = (state == WAIT_ACK) && !rdPtrAck_in;
`endif

   // The returning read plus buffered lines never exceed the 2-entry FIFO,
   // so a stalled consumer can never cause a line to be dropped.
   assign issue     = enable_in && !empty && !blocked &&
                      ((fifo_cnt + {1'b0, rd_pend}) < 2'd2);
   assign last_line = issue && (&line);

   // RAM data bypasses the FIFO when it is empty: this is what gives the
   // two-cycle wrPtr-to-first-line latency and one line per cycle.
   assign dataValid_out = (fifo_cnt != 2'd0) || rd_pend;
   assign data_out      = (fifo_cnt != 2'd0) ? fifo_q0 :
                          (rd_pend ? ramData_in : '0);
   assign pop           = dataValid_out && dataReady_in;

   assign ramRead_out  = issue;
   assign ramAddr_out  = {rd_ptr, line};
   assign avail_out    = wr_ptr - rd_ptr;
   assign rdPtr_out    = req_ptr;
   assign rdPtrReq_out = req;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         req_ptr  <= '0;
         line     <= '0;
         req      <= 1'b0;
         rd_pend  <= 1'b0;
         fifo_cnt <= 2'd0;
         fifo_q0  <= '0;
         fifo_q1  <= '0;
`ifdef C2F_RDPTR_COALESCE_EN
         dirty    <= 1'b0;
`endif
      end else if (!enable_in) begin
         // Clearing rd_pend also throws away any RAM data still returning.
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         req_ptr  <= '0;
         line     <= '0;
         req      <= 1'b0;
         rd_pend  <= 1'b0;
         fifo_cnt <= 2'd0;
         fifo_q0  <= '0;
         fifo_q1  <= '0;
`ifdef C2F_RDPTR_COALESCE_EN
         dirty    <= 1'b0;
`endif
      end else begin
         if (wrPtrValid_in) wr_ptr <= wrPtr_in;

         rd_pend <= issue;
         if (issue) begin
            line <= line + 1'b1;
            if (last_line) rd_ptr <= rd_ptr + 1'b1;
         end

         // Output FIFO. rd_pend with two entries held cannot occur.
         case (fifo_cnt)
            2'd0: begin
               if (rd_pend && !pop) begin
                  fifo_q0  <= ramData_in;
                  fifo_cnt <= 2'd1;
               end
            end
            2'd1: begin
               if (pop && rd_pend) begin
                  fifo_q0 <= ramData_in;
               end else if (pop) begin
                  fifo_cnt <= 2'd0;
               end else if (rd_pend) begin
                  fifo_q1  <= ramData_in;
                  fifo_cnt <= 2'd2;
               end
            end
            default: begin
               if (pop) begin
                  fifo_q0  <= fifo_q1;
                  fifo_cnt <= 2'd1;
               end
            end
         endcase

`ifdef C2F_RDPTR_COALESCE_EN
         case (state)
            IDLE:    if (!empty) state <= STREAM;
            default: if (empty)  state <= IDLE;
         endcase

         if (req) begin
            if (rdPtrAck_in) req <= 1'b0;
            dirty <= dirty | last_line;
         end else if (dirty || last_line) begin
            req     <= 1'b1;
            req_ptr <= last_line ? rd_ptr + 1'b1 : rd_ptr;
            dirty   <= 1'b0;
         end
`else
         if (last_line) begin
            state   <= WAIT_ACK;
            req     <= 1'b1;
            req_ptr <= rd_ptr + 1'b1;
         end else begin
            case (state)
               IDLE:     if (!empty) state <= STREAM;
               STREAM:   if (empty)  state <= IDLE;
               WAIT_ACK: begin
                  if (rdPtrAck_in) begin
                     req   <= 1'b0;
                     state <= empty ? IDLE : STREAM;
                  end
               end
               default:  state <= IDLE;
            endcase
         end
`endif
      end
   end

endmodule

// File: tb/tb_c2f_chunk_ring.sv
// Directed bench for c2f_chunk_ring at default parameters. A RAM model
// returns pat(addr) one cycle after each read strobe; monitors log accepted
// lines, issued addresses and rising read-pointer requests.

module tb_c2f_chunk_ring;

   localparam int CW = 2;
   localparam int LW = 3;
   localparam int DW = 64;

   logic          clk_in = 1'b0;
   logic          reset_in = 1'b0;
   logic          enable_in = 1'b0;
   logic          wrPtrValid_in = 1'b0;
   logic [CW-1:0] wrPtr_in = '0;
   logic [CW+LW-1:0] ramAddr_out;
   logic          ramRead_out;
   logic [DW-1:0] ramData_in = '0;
   logic [DW-1:0] data_out;
   logic          dataValid_out;
   logic          dataReady_in = 1'b1;
   logic [CW-1:0] rdPtr_out;
   logic          rdPtrReq_out;
   logic          rdPtrAck_in = 1'b0;
   logic [CW-1:0] avail_out;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ready_mode = 0;   // 0 high, 1 toggle, 2 low
   int ack_delay = 0;
   int age = 0;
   logic prev_req = 1'b0;

   logic [DW-1:0] got[$];
   int addrs[$];
   int addr_cyc[$];
   int reqs[$];
   int req_cyc[$];

   c2f_chunk_ring dut (
      .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
      .wrPtrValid_in(wrPtrValid_in), .wrPtr_in(wrPtr_in),
      .ramAddr_out(ramAddr_out), .ramRead_out(ramRead_out), .ramData_in(ramData_in),
      .data_out(data_out), .dataValid_out(dataValid_out), .dataReady_in(dataReady_in),
      .rdPtr_out(rdPtr_out), .rdPtrReq_out(rdPtrReq_out), .rdPtrAck_in(rdPtrAck_in),
      .avail_out(avail_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [DW-1:0] pat(input int a);
      return {32'hC2F0_0000 | 32'(a), ~32'(a)};
   endfunction

   always @(posedge clk_in) begin
      cyc <= cyc + 1;
      if (ramRead_out) ramData_in <= pat(int'(ramAddr_out));
      else             ramData_in <= 64'hDEAD_BEEF_DEAD_BEEF;
   end

   always @(posedge clk_in) begin
      #1;
      case (ready_mode)
         0:       dataReady_in = 1'b1;
         1:       dataReady_in = ~dataReady_in;
         default: dataReady_in = 1'b0;
      endcase
      if (rdPtrReq_out && !rdPtrAck_in) begin
         if (age >= ack_delay) rdPtrAck_in = 1'b1;
         else age++;
      end else begin
         rdPtrAck_in = 1'b0;
         age = 0;
      end
   end

   always @(negedge clk_in) begin
      if (dataValid_out && dataReady_in) got.push_back(data_out);
      if (ramRead_out) begin
         addrs.push_back(int'(ramAddr_out));
         addr_cyc.push_back(cyc);
      end
      if (rdPtrReq_out && !prev_req) begin
         reqs.push_back(int'(rdPtr_out));
         req_cyc.push_back(cyc);
      end
      prev_req = rdPtrReq_out;
   end

   // First index where the logged lines differ from pat(i % m), or where
   // fewer than n lines were logged; -1 when all n match.
   function automatic int first_bad_data(input int n, input int m);
      for (int i = 0; i < n; i++)
         if (i >= got.size() || got[i] !== pat(i % m)) return i;
      return -1;
   endfunction

   function automatic int first_bad_addr(input int n, input int m);
      for (int i = 0; i < n; i++)
         if (i >= addrs.size() || addrs[i] != (i % m)) return i;
      return -1;
   endfunction

   task automatic clear_logs();
      got.delete(); addrs.delete(); addr_cyc.delete();
      reqs.delete(); req_cyc.delete();
   endtask

   task automatic do_reset();
      @(posedge clk_in); #1;
      reset_in = 1'b1; enable_in = 1'b1; wrPtrValid_in = 1'b0;
      ready_mode = 0; ack_delay = 0;
      repeat (2) @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      clear_logs();
   endtask

   task automatic write_wr(input int p);
      @(posedge clk_in); #1;
      wrPtrValid_in = 1'b1; wrPtr_in = CW'(p);
      @(posedge clk_in); #1;
      wrPtrValid_in = 1'b0;
   endtask

   task automatic wait_until(input int nlines, input int nreqs, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_in); #1;
         if (got.size() >= nlines && reqs.size() >= nreqs) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_in = 1'b1; enable_in = 1'b1;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      checks++; if (dataValid_out !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b exp 0", dataValid_out); end
      checks++; if (data_out !== '0) begin failures++; $display("FAIL rst_data: got %0h exp 0", data_out); end
      checks++; if (ramRead_out !== 1'b0) begin failures++; $display("FAIL rst_read: got %0b exp 0", ramRead_out); end
      checks++; if (ramAddr_out !== '0) begin failures++; $display("FAIL rst_addr: got %0h exp 0", ramAddr_out); end
      checks++; if (rdPtrReq_out !== 1'b0 || rdPtr_out !== '0) begin failures++; $display("FAIL rst_req: got req=%0b ptr=%0d exp 0/0", rdPtrReq_out, rdPtr_out); end
      checks++; if (avail_out !== '0) begin failures++; $display("FAIL rst_avail: got %0d exp 0", avail_out); end
      @(posedge clk_in); #1;
      reset_in = 1'b0;
      clear_logs();
   endtask

   task automatic test_single_chunk();
      bit ok;
      int b;
      do_reset();
      @(posedge clk_in); #1;
      wrPtrValid_in = 1'b1; wrPtr_in = 2'd1;
      @(negedge clk_in);
      checks++; if (avail_out !== 2'd0 || ramRead_out !== 1'b0) begin failures++; $display("FAIL wr_cycle: got avail=%0d read=%0b exp 0/0", avail_out, ramRead_out); end
      @(posedge clk_in); #1;
      wrPtrValid_in = 1'b0;
      @(negedge clk_in);
      checks++; if (ramRead_out !== 1'b1 || ramAddr_out !== 5'd0 || avail_out !== 2'd1) begin failures++; $display("FAIL first_read: got read=%0b addr=%0d avail=%0d exp 1/0/1", ramRead_out, ramAddr_out, avail_out); end
      @(negedge clk_in);
      checks++; if (dataValid_out !== 1'b1 || data_out !== pat(0)) begin failures++; $display("FAIL latency2: got valid=%0b data=%0h exp 1/%0h", dataValid_out, data_out, pat(0)); end
      wait_until(8, 1, 40, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got lines=%0d reqs=%0d exp 8/1", got.size(), reqs.size()); end
      b = first_bad_data(8, 32);
      checks++; if (b != -1 || got.size() != 8) begin failures++; $display("FAIL single_data: got first_bad=%0d count=%0d exp -1/8", b, got.size()); end
      b = first_bad_addr(8, 32);
      checks++; if (b != -1) begin failures++; $display("FAIL single_addr: got first_bad=%0d exp -1", b); end
      checks++; if (reqs.size() != 1 || rdPtr_out !== 2'd1 || avail_out !== 2'd0) begin failures++; $display("FAIL single_req: got reqs=%0d ptr=%0d avail=%0d exp 1/1/0", reqs.size(), rdPtr_out, avail_out); end
   endtask

   task automatic test_ready_toggle();
      bit done = 1'b0;
      bit prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      int stall_bad = 0;
      int b;
      do_reset();
      ready_mode = 1;
      write_wr(3);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_in);
         if (prev_stall && (dataValid_out !== 1'b1 || data_out !== prev_data)) stall_bad++;
         prev_stall = dataValid_out && !dataReady_in;
         prev_data  = data_out;
         if (got.size() >= 24 && reqs.size() >= 3) begin done = 1'b1; break; end
      end
      checks++; if (!done) begin failures++; $display("FAIL toggle_timeout: got lines=%0d reqs=%0d exp 24/3", got.size(), reqs.size()); end
      checks++; if (stall_bad != 0) begin failures++; $display("FAIL toggle_stable: got %0d unstable stalls exp 0", stall_bad); end
      repeat (4) @(negedge clk_in);
      b = first_bad_data(24, 32);
      checks++; if (b != -1 || got.size() != 24) begin failures++; $display("FAIL toggle_data: got first_bad=%0d count=%0d exp -1/24", b, got.size()); end
      checks++; if (reqs.size() != 3 || rdPtr_out !== 2'd3 || avail_out !== 2'd0) begin failures++; $display("FAIL toggle_rdptr: got reqs=%0d ptr=%0d avail=%0d exp 3/3/0", reqs.size(), rdPtr_out, avail_out); end
      ready_mode = 0;
   endtask

   task automatic test_wrap();
      bit ok;
      int b;
      int exp_rq[5] = '{1, 2, 3, 0, 1};
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         write_wr(k % 4);
         wait_until(8 * k, k, 60, ok);
         checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout_%0d: got lines=%0d reqs=%0d exp %0d/%0d", k, got.size(), reqs.size(), 8 * k, k); end
      end
      b = first_bad_addr(40, 32);
      checks++; if (b != -1) begin failures++; $display("FAIL wrap_addr: got first_bad=%0d exp -1", b); end
      b = first_bad_data(40, 32);
      checks++; if (b != -1) begin failures++; $display("FAIL wrap_data: got first_bad=%0d exp -1", b); end
      b = -1;
      if (reqs.size() != 5) b = 99;
      else for (int i = 0; i < 5; i++) if (b < 0 && reqs[i] != exp_rq[i]) b = i;
      checks++; if (b != -1) begin failures++; $display("FAIL wrap_rdptr_seq: got bad_at=%0d size=%0d exp -1/5", b, reqs.size()); end
   endtask

   task automatic test_ack_delay();
      bit ok;
      int b;
      int a8 = -1;
      int r0 = -1;
      do_reset();
      ack_delay = 20;
      write_wr(2);
      wait_until(16, 2, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ack_timeout: got lines=%0d reqs=%0d exp 16/2", got.size(), reqs.size()); end
      b = first_bad_data(16, 32);
      checks++; if (b != -1) begin failures++; $display("FAIL ack_data: got first_bad=%0d exp -1", b); end
      checks++; if (reqs.size() != 2 || reqs[0] != 1 || reqs[1] != 2) begin failures++; $display("FAIL ack_reqs: got size=%0d first=%0d exp 2 requests 1,2", reqs.size(), (reqs.size() > 0) ? reqs[0] : -1); end
      if (addr_cyc.size() > 8) a8 = addr_cyc[8];
      if (req_cyc.size() > 0)  r0 = req_cyc[0];
`ifdef C2F_RDPTR_COALESCE_EN
      checks++; if (a8 < 0 || r0 < 0 || a8 >= r0 + 20) begin failures++; $display("FAIL ack_stream: got addr8_cyc=%0d req_cyc=%0d exp addr8 before ack", a8, r0); end
`else
      checks++; if (a8 < 0 || r0 < 0 || a8 < r0 + 20) begin failures++; $display("FAIL ack_block: got addr8_cyc=%0d req_cyc=%0d exp addr8 at/after ack", a8, r0); end
`endif
      ack_delay = 0;
   endtask

   task automatic test_enable_clear();
      bit ok;
      int n;
      do_reset();
      write_wr(1);
      wait_until(3, 0, 20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL en_timeout: got lines=%0d exp 3", got.size()); end
      ready_mode = 2;
      @(posedge clk_in); #1;
      enable_in = 1'b0;
      @(negedge clk_in);
      checks++; if (ramRead_out !== 1'b0) begin failures++; $display("FAIL en_read_gate: got %0b exp 0", ramRead_out); end
      @(posedge clk_in); #1;
      enable_in = 1'b1;
      ready_mode = 0;
      @(negedge clk_in);
      checks++; if (dataValid_out !== 1'b0 || rdPtrReq_out !== 1'b0 || avail_out !== 2'd0) begin failures++; $display("FAIL en_clear: got valid=%0b req=%0b avail=%0d exp 0/0/0", dataValid_out, rdPtrReq_out, avail_out); end
      n = got.size();
      repeat (10) @(negedge clk_in);
      checks++; if (got.size() != n) begin failures++; $display("FAIL en_stale: got %0d lines exp %0d", got.size(), n); end
   endtask

   task automatic test_async_reset();
      bit ok;
      int n;
      int b;
      do_reset();
      write_wr(1);
      wait_until(3, 0, 20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ar_timeout: got lines=%0d exp 3", got.size()); end
      #1 reset_in = 1'b1;
      #1;
      checks++; if (dataValid_out !== 1'b0 || ramRead_out !== 1'b0 || avail_out !== 2'd0 || ramAddr_out !== '0 || data_out !== '0) begin failures++; $display("FAIL ar_immediate: got valid=%0b read=%0b avail=%0d addr=%0d exp all 0", dataValid_out, ramRead_out, avail_out, ramAddr_out); end
      #1 reset_in = 1'b0;
      n = got.size();
      repeat (10) @(posedge clk_in);
      #1;
      checks++; if (got.size() != n) begin failures++; $display("FAIL ar_partial: got %0d lines exp %0d", got.size(), n); end
      clear_logs();
      write_wr(1);
      wait_until(8, 1, 40, ok);
      b = first_bad_data(8, 32);
      checks++; if (!ok || b != -1) begin failures++; $display("FAIL ar_restart_data: got ok=%0b first_bad=%0d exp 1/-1", ok, b); end
      b = first_bad_addr(8, 32);
      checks++; if (b != -1) begin failures++; $display("FAIL ar_restart_addr: got first_bad=%0d exp -1", b); end
   endtask

   initial begin
      test_reset();
      test_single_chunk();
      test_ready_toggle();
      test_wrap();
      test_ack_delay();
      test_enable_clear();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
